// File: rtl/counter_ctrl.sv
// counter_ctrl: switch/button sequencer producing mode, direction and tick strobes for the LED counter.
// Define COUNTER_CTRL_DEBOUNCE_EN to build the button debounce filter; otherwise btnD follows btnS.
module counter_ctrl #(
  parameter int cN  = 24,
  parameter int cDB = 16
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic [3:0] iSW,
  input  logic       iBTN,
  output logic       oTick,
  output logic [1:0] oMode,
  output logic       oDir,
  output logic [1:0] oState
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} tState;
  tState state;
  logic [3:0] swMeta, swS;
  logic btnMeta, btnS, btnD, btnDPrev;
  logic [cN-1:0] presc;
  logic [1:0] modeDec;
  logic prescClr, stepEdge;
  always_comb begin
    modeDec  = swS[3] ? 2'b11 : swS[2] ? 2'b10 : swS[1] ? 2'b01 : 2'b00;
    prescClr = (state != RUN) || (modeDec != oMode);
    stepEdge = btnD & ~btnDPrev;
  end
  assign oState = state;
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      swMeta  <= '0;
      swS     <= '0;
      btnMeta <= 1'b0;
      btnS    <= 1'b0;
    end else begin
      swMeta  <= iSW;
      swS     <= swMeta;
      btnMeta <= iBTN;
      btnS    <= btnMeta;
    end
  end
  // Step only fires when staying in IDLE, so a simultaneous IDLE->RUN entry drops it.
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state    <= IDLE;
      oMode    <= 2'b00;
      oDir     <= 1'b1;
      oTick    <= 1'b0;
      presc    <= '0;
      btnDPrev <= 1'b0;
    end else begin
      state    <= !swS[0] ? IDLE : (modeDec == 2'b00) ? HALT : RUN;
      oMode    <= modeDec;
      oDir     <= (modeDec == 2'b00) ? oDir : (modeDec != 2'b10);
      presc    <= prescClr ? '0 : presc + 1'b1;
      btnDPrev <= btnD;
      oTick    <= (!prescClr && presc == '1) ||
                  (state == IDLE && !swS[0] && oMode != 2'b00 && stepEdge);
    end
  end
`ifdef COUNTER_CTRL_DEBOUNCE_EN
  logic [cDB-1:0] dbCnt;
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      dbCnt <= '0;
      btnD  <= 1'b0;
    end else if (btnS == btnD) begin
      dbCnt <= '0;
    end else if (dbCnt == '1) begin
      btnD  <= btnS;
      dbCnt <= '0;
    end else begin
      dbCnt <= dbCnt + 1'b1;
    end
  end
`else
  assign btnD = btnS;
`endif
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: scoreboard bench for counter_ctrl with cN=2, cDB=2 and a 4 ns clock.
module tb_counter_ctrl;
  logic iCLK_50 = 1'b0;
  logic iRST, iBTN, oTick, oDir;
  logic [3:0] iSW;
  logic [1:0] oMode, oState;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

`ifdef COUNTER_CTRL_DEBOUNCE_EN
  localparam int STEP_LAT = 7;
  localparam int GLITCH_LAT = 0;
`else
  localparam int STEP_LAT = 3;
  localparam int GLITCH_LAT = 3;
`endif

  typedef struct {
    int    cyc;
    string tag;
    int    sel;
    int    val;
  } tExp;
  tExp q[$];

  counter_ctrl #(.cN(2), .cDB(2)) dut (
    .iCLK_50(iCLK_50),
    .iRST(iRST),
    .iSW(iSW),
    .iBTN(iBTN),
    .oTick(oTick),
    .oMode(oMode),
    .oDir(oDir),
    .oState(oState)
  );

  always #2 iCLK_50 = ~iCLK_50;
  always @(posedge iCLK_50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] observe(input int sel);
    return sel == 0 ? {7'd0, oTick} : sel == 1 ? {6'd0, oMode} :
           sel == 2 ? {7'd0, oDir} : {6'd0, oState};
  endfunction

  // Expectation for the outputs seen after the clock edge dc cycles from now.
  task automatic expectAt(input int dc, input string tag, input int sel, input int val);
    tExp e;
    e.cyc = cyc + dc;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge iCLK_50);
    #1;
  endtask

  always @(negedge iCLK_50) begin
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].cyc == cyc) begin
        check(q[i].tag, observe(q[i].sel), q[i].val[7:0]);
        q.delete(i);
      end
  end

  initial begin
    iRST = 1'b1;
    iSW  = 4'b1111;
    iBTN = 1'b0;
    waitClk(2);
    expectAt(0, "rst_tick", 0, 0);
    expectAt(0, "rst_mode", 1, 0);
    expectAt(0, "rst_dir", 2, 1);
    expectAt(0, "rst_state", 3, 0);
    iRST = 1'b0;
    for (int k = 1; k <= 3; k++) expectAt(k, "rel_tick", 0, 0);
    expectAt(2, "rel_state", 3, 0);
    expectAt(3, "ring_state", 3, 1);
    expectAt(3, "ring_mode", 1, 3);
    waitClk(4);
    iSW = 4'b0101;
    expectAt(2, "pri_mode_old", 1, 3);
    expectAt(2, "pri_dir_old", 2, 1);
    expectAt(3, "pri_mode", 1, 2);
    expectAt(3, "pri_dir", 2, 0);
    for (int k = 2; k <= 6; k++) expectAt(k, "restart_quiet", 0, 0);
    expectAt(7, "restart_tick", 0, 1);
    expectAt(8, "restart_after", 0, 0);
    waitClk(9);
    iSW = 4'b0000;
    expectAt(3, "idle_state", 3, 0);
    expectAt(3, "idle_mode", 1, 0);
    expectAt(3, "idle_dir_hold", 2, 0);
    expectAt(3, "idle_tick", 0, 0);
    expectAt(4, "idle_tick", 0, 0);
    waitClk(5);
    iSW = 4'b0011;
    expectAt(2, "up_state_pre", 3, 0);
    expectAt(3, "up_state", 3, 1);
    expectAt(3, "up_mode", 1, 1);
    expectAt(3, "up_dir", 2, 1);
    for (int k = 3; k <= 12; k++) expectAt(k, "up_tick", 0, (k == 7 || k == 11) ? 1 : 0);
    waitClk(12);
    iSW = 4'b0001;
    expectAt(3, "halt_state", 3, 2);
    expectAt(3, "halt_mode", 1, 0);
    expectAt(3, "halt_dir", 2, 1);
    for (int k = 3; k <= 10; k++) expectAt(k, "halt_tick", 0, 0);
    waitClk(11);
    iSW = 4'b0010;
    expectAt(3, "step_idle", 3, 0);
    expectAt(3, "step_mode", 1, 1);
    waitClk(4);
    iBTN = 1'b1;
    for (int k = 1; k <= 12; k++) expectAt(k, "step_tick", 0, (k == STEP_LAT) ? 1 : 0);
    waitClk(10);
    iBTN = 1'b0;
    for (int k = 1; k <= 10; k++) expectAt(k, "release_tick", 0, 0);
    waitClk(10);
    iBTN = 1'b1;
    for (int k = 1; k <= 12; k++) expectAt(k, "glitch_tick", 0, (k == GLITCH_LAT) ? 1 : 0);
    waitClk(2);
    iBTN = 1'b0;
    waitClk(10);
    iSW = 4'b0011;
    expectAt(3, "runbtn_state", 3, 1);
    for (int k = 4; k <= 20; k++)
      expectAt(k, "runbtn_tick", 0, (k >= 7 && (k - 7) % 4 == 0) ? 1 : 0);
    waitClk(9);
    iBTN = 1'b1;
    waitClk(10);
    iBTN = 1'b0;
    waitClk(3);
    iRST = 1'b1;
    expectAt(1, "rstmid_tick", 0, 0);
    expectAt(1, "rstmid_state", 3, 0);
    expectAt(1, "rstmid_mode", 1, 0);
    waitClk(1);
    iRST = 1'b0;
    for (int k = 1; k <= 6; k++) expectAt(k, "reentry_quiet", 0, 0);
    expectAt(2, "reentry_idle", 3, 0);
    expectAt(3, "reentry_state", 3, 1);
    expectAt(7, "reentry_tick", 0, 1);
    for (int n = 0; n < 40 && q.size() > 0; n++) waitClk(1);
    foreach (q[i]) check({"unreached_", q[i].tag}, 8'hFF, q[i].val[7:0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
